// File: rtl/galaksija_uart_pkg.sv
// Shared types and constants for the Galaksija serial transmitter.
// GALAKSIJA_UART_TX_PARITY_EN selects 8E1 framing instead of 8N1.
package galaksija_uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } state_e;

`ifdef GALAKSIJA_UART_TX_PARITY_EN
  localparam int unsigned C_FRAME_BITS = 11;
`else
  localparam int unsigned C_FRAME_BITS = 10;
`endif

  // Rounded clocks per bit; never below 2 so the divider has a range.
  function automatic int unsigned baud_div(
    input int unsigned clk_hz,
    input int unsigned baud
  );
    int unsigned d;
    d = (clk_hz + baud / 2) / baud;
    return (d < 2) ? 2 : d;
  endfunction

endpackage

// File: rtl/galaksija_uart_tx_if.sv
// Byte handshake from the core into the serial transmitter.
// Plain valid/ready: a byte moves when both are high.
interface galaksija_uart_tx_if;

  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;

  modport master (
    output tx_data,
    output tx_valid,
    input  tx_ready
  );

  modport slave (
    input  tx_data,
    input  tx_valid,
    output tx_ready
  );

endinterface

// File: rtl/galaksija_uart_fifo.sv
// Single-clock byte FIFO, head visible combinationally.
// Writes when full and reads when empty are ignored.
module galaksija_uart_fifo #(
  parameter int C_depth_log2 = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  wr_en,
  input  logic [7:0]            wr_data,
  input  logic                  rd_en,
  output logic [7:0]            rd_data,
  output logic [C_depth_log2:0] count,
  output logic                  full,
  output logic                  empty
);

  localparam int C_depth = 1 << C_depth_log2;
  localparam logic [C_depth_log2:0] C_full =
    (C_depth_log2 + 1)'(C_depth);

  logic [7:0]              mem_q [C_depth];
  logic [C_depth_log2-1:0] wr_ptr_q, wr_ptr_d;
  logic [C_depth_log2-1:0] rd_ptr_q, rd_ptr_d;
  logic [C_depth_log2:0]   count_q, count_d;
  logic                    do_wr, do_rd;

  assign full    = (count_q == C_full);
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign rd_data = mem_q[rd_ptr_q];
  assign do_wr   = wr_en & ~full;
  assign do_rd   = rd_en & ~empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_wr) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_rd) rd_ptr_d = rd_ptr_q + 1'b1;
    if (do_wr && !do_rd) count_d = count_q + 1'b1;
    if (!do_wr && do_rd) count_d = count_q - 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem_q[wr_ptr_q] <= wr_data;
  end

endmodule

// File: rtl/galaksija_uart_tx.sv
// Galaksija serial transmitter: FIFO-fed, LSB first, idle-high line.
// GALAKSIJA_UART_TX_PARITY_EN adds an even parity bit (8E1).
module galaksija_uart_tx
  import galaksija_uart_pkg::*;
#(
  parameter int unsigned C_clk_freq_hz     = 25000000,
  parameter int unsigned C_baud            = 115200,
  parameter int          C_fifo_depth_log2 = 4
) (
  input  logic                       clk,
  input  logic                       reset_n,
  galaksija_uart_tx_if.slave         tx_if,
  output logic                       ser_tx,
  output logic                       busy,
  output logic [C_fifo_depth_log2:0] fifo_count
);

  localparam int unsigned C_div = baud_div(C_clk_freq_hz, C_baud);
  localparam int C_dw = $clog2(C_div);
  localparam logic [C_dw-1:0] C_div_last = C_dw'(C_div - 1);

  state_e          state_q, state_d;
  logic [C_dw-1:0] div_q, div_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      shreg_q, shreg_d;
  logic            ser_tx_q, ser_tx_d;
  logic            pop, tick;
  logic [7:0]      fifo_head;
  logic            fifo_full, fifo_empty;
`ifdef GALAKSIJA_UART_TX_PARITY_EN
  logic            parity_q, parity_d;
`endif

  galaksija_uart_fifo #(
    .C_depth_log2 (C_fifo_depth_log2)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .wr_en   (tx_if.tx_valid & tx_if.tx_ready),
    .wr_data (tx_if.tx_data),
    .rd_en   (pop),
    .rd_data (fifo_head),
    .count   (fifo_count),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign tx_if.tx_ready = ~fifo_full;
  assign tick   = (div_q == C_div_last);
  assign ser_tx = ser_tx_q;
  assign busy   = (state_q != ST_IDLE) | (fifo_count != '0);

  always_comb begin
    state_d = state_q;
    div_d   = div_q + 1'b1;
    bit_d   = bit_q;
    shreg_d = shreg_q;
    pop     = 1'b0;
`ifdef GALAKSIJA_UART_TX_PARITY_EN
    parity_d = parity_q;
`endif
    unique case (state_q)
      ST_IDLE: begin
        div_d = '0;
        if (!fifo_empty) begin
          pop     = 1'b1;
          state_d = ST_START;
        end
      end
      ST_START: if (tick) begin
        div_d   = '0;
        bit_d   = '0;
        state_d = ST_DATA;
      end
      ST_DATA: if (tick) begin
        div_d   = '0;
        bit_d   = bit_q + 1'b1;
        shreg_d = {1'b0, shreg_q[7:1]};
`ifdef GALAKSIJA_UART_TX_PARITY_EN
        if (bit_q == 3'd7) state_d = ST_PARITY;
`else
        if (bit_q == 3'd7) state_d = ST_STOP;
`endif
      end
`ifdef GALAKSIJA_UART_TX_PARITY_EN
      ST_PARITY: if (tick) begin
        div_d   = '0;
        state_d = ST_STOP;
      end
`endif
      ST_STOP: if (tick) begin
        // Last stop cycle: chain the next frame with no idle gap.
        div_d   = '0;
        pop     = !fifo_empty;
        state_d = fifo_empty ? ST_IDLE : ST_START;
      end
      default: begin
        div_d   = '0;
        state_d = ST_IDLE;
      end
    endcase
    if (pop) begin
      shreg_d = fifo_head;
`ifdef GALAKSIJA_UART_TX_PARITY_EN
      parity_d = ^fifo_head;
`endif
    end
    // Line level follows the next state so it lines up with it.
    unique case (state_d)
      ST_START:  ser_tx_d = 1'b0;
      ST_DATA:   ser_tx_d = shreg_d[0];
`ifdef GALAKSIJA_UART_TX_PARITY_EN
      ST_PARITY: ser_tx_d = parity_q;
`endif
      default:   ser_tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      div_q    <= '0;
      bit_q    <= '0;
      shreg_q  <= '0;
      ser_tx_q <= 1'b1;
`ifdef GALAKSIJA_UART_TX_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      div_q    <= div_d;
      bit_q    <= bit_d;
      shreg_q  <= shreg_d;
      ser_tx_q <= ser_tx_d;
`ifdef GALAKSIJA_UART_TX_PARITY_EN
      parity_q <= parity_d;
`endif
    end
  end

endmodule

// File: tb/tb_galaksija_uart_tx.sv
// Directed bench for galaksija_uart_tx at DIV=10 (1 MHz / 100 kbaud).
// Honours GALAKSIJA_UART_TX_PARITY_EN for frame length and parity bit.
module tb_galaksija_uart_tx;

`ifdef GALAKSIJA_UART_TX_PARITY_EN
  localparam int FB = 11;
`else
  localparam int FB = 10;
`endif

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       ser_tx;
  logic       busy;
  logic [4:0] fifo_count;

  int n_cmp = 0;
  int n_err = 0;

  galaksija_uart_tx_if tx_if ();

  galaksija_uart_tx #(
    .C_clk_freq_hz     (1000000),
    .C_baud            (100000),
    .C_fifo_depth_log2 (4)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .tx_if      (tx_if),
    .ser_tx     (ser_tx),
    .busy       (busy),
    .fifo_count (fifo_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic push(input logic [7:0] b, output logic acc);
    tx_if.tx_data  = b;
    tx_if.tx_valid = 1'b1;
    acc = tx_if.tx_ready;
    @(negedge clk);
    tx_if.tx_valid = 1'b0;
  endtask

  task automatic rx_byte(output logic [7:0] b, output logic par);
    int n;
    n = 0;
    b = '0;
    par = 1'b0;
    while (ser_tx !== 1'b0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (ser_tx !== 1'b0) begin
      check("rx_start_timeout", 1, 0);
      return;
    end
    repeat (5) @(negedge clk);
    check("rx_start_mid", ser_tx, 0);
    for (int i = 0; i < 8; i++) begin
      repeat (10) @(negedge clk);
      b[i] = ser_tx;
    end
`ifdef GALAKSIJA_UART_TX_PARITY_EN
    repeat (10) @(negedge clk);
    par = ser_tx;
`endif
    repeat (10) @(negedge clk);
    check("rx_stop", ser_tx, 1);
  endtask

  task automatic busy_len(output int n);
    int w;
    w = 0;
    n = 0;
    while (ser_tx !== 1'b0 && w < 400) begin
      @(negedge clk);
      w++;
    end
    while (busy === 1'b1 && n < 4000) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy !== 1'b0 && n < 4000) begin
      @(negedge clk);
      n++;
    end
    check("idle_timeout", busy, 0);
    repeat (20) @(negedge clk);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic       acc, e, par, prev;
    logic [7:0] b, t2b;
    int         len, edges;

    tx_if.tx_data  = '0;
    tx_if.tx_valid = 1'b0;

    // Reset state and quiet line.
    repeat (3) @(negedge clk);
    check("rst_ser_tx", ser_tx, 1);
    check("rst_ready", tx_if.tx_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_count", fifo_count, 0);
    reset_n = 1'b1;
    edges = 0;
    prev = ser_tx;
    repeat (200) begin
      @(negedge clk);
      if (ser_tx !== prev) edges++;
      prev = ser_tx;
    end
    check("idle_edges", edges, 0);

    // Single byte, cycle-exact waveform.
    t2b = 8'h55;
    push(t2b, acc);
    check("t2_acc", acc, 1);
    check("t2_count", fifo_count, 1);
    check("t2_busy", busy, 1);
    for (int k = 1; k <= 2 + 10 * FB; k++) begin
      if (k < 2) e = 1'b1;
      else if (k < 12) e = 1'b0;
      else if (k < 92) e = t2b[(k - 12) / 10];
      else if (FB == 11 && k < 102) e = ^t2b;
      else e = 1'b1;
      check("t2_line", ser_tx, e);
      if (k == 1 + 10 * FB) check("t2_busy_hi", busy, 1);
      if (k == 2 + 10 * FB) check("t2_busy_lo", busy, 0);
      if (k < 2 + 10 * FB) @(negedge clk);
    end
    wait_idle();

    // Back-to-back frames with no gap.
    fork
      begin
        push(8'hA3, acc);
        push(8'h0F, acc);
        push(8'hFF, acc);
      end
      begin
        rx_byte(b, par);
        check("t3_b0", b, 8'hA3);
        rx_byte(b, par);
        check("t3_b1", b, 8'h0F);
        rx_byte(b, par);
        check("t3_b2", b, 8'hFF);
      end
      begin
        busy_len(len);
        check("t3_len", len, 3 * 10 * FB);
      end
    join
    wait_idle();

    // Fill the FIFO, refuse one, drain in order.
    fork
      begin
        for (int i = 0; i < 17; i++) begin
          push(8'h10 + 8'(i), acc);
          check("t4_acc", acc, 1);
        end
        check("t4_ready", tx_if.tx_ready, 0);
        check("t4_full", fifo_count, 16);
        push(8'hEE, acc);
        check("t4_refused", acc, 0);
        check("t4_still", fifo_count, 16);
      end
      begin
        for (int i = 0; i < 17; i++) begin
          rx_byte(b, par);
          check("t4_order", b, 8'h10 + 8'(i));
        end
      end
    join
    wait_idle();

    // Reset in the middle of bit 3 of 0xC3.
    push(8'hC3, acc);
    push(8'h11, acc);
    push(8'h22, acc);
    push(8'h33, acc);
    push(8'h44, acc);
    repeat (40) @(negedge clk);
    check("t5_bit3", ser_tx, 0);
    check("t5_queued", fifo_count, 4);
    #2 reset_n = 1'b0;
    #1;
    check("t5_line", ser_tx, 1);
    check("t5_count", fifo_count, 0);
    check("t5_busy", busy, 0);
    check("t5_ready", tx_if.tx_ready, 1);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    edges = 0;
    repeat (300) begin
      @(negedge clk);
      if (ser_tx !== 1'b1 || busy !== 1'b0) edges++;
    end
    check("t5_silent", edges, 0);

    // Frame length and parity bit.
    fork
      push(8'h07, acc);
      begin
        rx_byte(b, par);
        check("t6_b07", b, 8'h07);
`ifdef GALAKSIJA_UART_TX_PARITY_EN
        check("t6_par07", par, 1);
`endif
      end
      begin
        busy_len(len);
        check("t6_len", len, 10 * FB);
      end
    join
    wait_idle();
    fork
      push(8'h03, acc);
      begin
        rx_byte(b, par);
        check("t6_b03", b, 8'h03);
`ifdef GALAKSIJA_UART_TX_PARITY_EN
        check("t6_par03", par, 0);
`endif
      end
    join
    wait_idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
